// File: rtl/chorus_pkg.sv
// -----------------------------------------------------------------------------
// chorus_pkg
//
// Shared definitions for the multi-voice chorus:
//   - chorus_state_t : sequencer states (IDLE, READ, MIX, DONE)
//   - MIX_SHIFT      : dry/wet weights are in 1/16 steps, so the weighted sum
//                      is scaled back down by this many bits
//   - delay_to_off() : converts a delay in ms to a smart_ram byte offset
//   - voices_legal() : legal voice counts (power of two so the wet average
//                      is a plain arithmetic shift)
//   - voice_spacing(): even-valued spacing between initial voice taps
//
// Optional feature macro used by the top level: CHORUS_LFO_FREEZE_EN.
// -----------------------------------------------------------------------------
package chorus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } chorus_state_t;

    localparam int MIX_SHIFT = 4;
    localparam int MIX_FULL  = 1 << MIX_SHIFT;

    // Offsets are in bytes and samples are two bytes wide, hence the 2x.
    function automatic int delay_to_off(input int ms, input int samplerate);
        return (2 * ms * samplerate) / 1000;
    endfunction

    function automatic bit voices_legal(input int voices);
        return (voices == 1) || (voices == 2) || (voices == 4) || (voices == 8);
    endfunction

    // Spacing is rounded down to an even value so every tap stays sample
    // aligned in the byte-addressed delay memory.
    function automatic int voice_spacing(input int min_off, input int max_off,
                                         input int voices);
        int raw;
        raw = (max_off - min_off) / voices;
        return raw - (raw % 2);
    endfunction

endpackage

// File: rtl/chorus_lfo.sv
// -----------------------------------------------------------------------------
// chorus_lfo
//
// Triangle sweep of one voice's delay tap. On each step strobe the position
// moves by step_size toward the current end of the range; hitting or passing
// an end clamps to that end and reverses the direction. Reset restores the
// initial position and an upward direction.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   step        : advance the sweep by one step this cycle
//   step_size   : step magnitude in bytes (even)
//   min_off     : lower end of the sweep (even)
//   max_off     : upper end of the sweep (even)
//   init_pos    : position loaded at reset (even)
//   pos         : current tap offset
// -----------------------------------------------------------------------------
module chorus_lfo #(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] step_size,
    input  logic [ADDR_WIDTH-1:0] min_off,
    input  logic [ADDR_WIDTH-1:0] max_off,
    input  logic [ADDR_WIDTH-1:0] init_pos,
    output logic [ADDR_WIDTH-1:0] pos
);

    logic                dir_down;
    // One extra bit so neither comparison can wrap near the address limit.
    logic [ADDR_WIDTH:0] pos_up;
    logic [ADDR_WIDTH:0] floor_plus_step;

    assign pos_up          = {1'b0, pos} + {1'b0, step_size};
    assign floor_plus_step = {1'b0, min_off} + {1'b0, step_size};

    always_ff @(posedge clk) begin
        if (rst) begin
            pos      <= init_pos;
            dir_down <= 1'b0;
        end else if (step) begin
            if (!dir_down) begin
                if (pos_up >= {1'b0, max_off}) begin
                    pos      <= max_off;
                    dir_down <= 1'b1;
                end else begin
                    pos <= pos_up[ADDR_WIDTH-1:0];
                end
            end else begin
                // pos - step <= min  <=>  pos <= min + step (no underflow)
                if ({1'b0, pos} <= floor_plus_step) begin
                    pos      <= min_off;
                    dir_down <= 1'b0;
                end else begin
                    pos <= pos - step_size;
                end
            end
        end
    end

endmodule

// File: rtl/chorus_multivoice.sv
// -----------------------------------------------------------------------------
// chorus_multivoice
//
// Multi-voice chorus. Each granted sample reads VOICES delayed samples from
// smart_ram (one tap per voice, each tap swept by its own triangle LFO),
// averages them into a wet signal and blends it with the dry input:
//   data_out = (dry*(16-m) + wet*m) >>> 4,  m = min(mix, 16)
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   cs, my_turn       : effect enable and scheduler grant; a sample starts
//                       when both are high in IDLE
//   data_in           : dry sample, latched at acceptance
//   mix               : wet amount 0..16 (larger values act as 16), sampled
//                       only in the MIX cycle
//   sram_data_in      : delayed sample returned by smart_ram
//   sram_read_finish  : smart_ram read-complete strobe
//   freeze            : (only with CHORUS_LFO_FREEZE_EN) holds the LFO
//                       counter and all tap positions in the DONE cycle
//   sram_rd           : one-cycle read request
//   sram_offset       : byte offset back in time for the request
//   done              : one-cycle completion pulse
//   data_out          : processed sample, held until the next MIX
//
// Read handshake: sram_rd is a single-cycle request carrying sram_offset.
// Exactly one request is outstanding; the next voice's request is raised in
// the same cycle that the previous sram_read_finish is seen, so a memory
// answering one cycle after each request gives done VOICES+3 cycles after
// the grant. A finish seen in the first request cycle, or outside READ, is
// not a response to an outstanding request and is ignored.
//
// Optional feature macro: CHORUS_LFO_FREEZE_EN (adds the freeze input).
// -----------------------------------------------------------------------------
module chorus_multivoice
    import chorus_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 13,
    parameter int SAMPLERATE   = 48000,
    parameter int VOICES       = 4,
    parameter int MIN_DELAY_MS = 10,
    parameter int MAX_DELAY_MS = 25,
    parameter int RATE_DIV     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  my_turn,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [4:0]            mix,
    input  logic [DATA_WIDTH-1:0] sram_data_in,
    input  logic                  sram_read_finish,
`ifdef CHORUS_LFO_FREEZE_EN
    input  logic                  freeze,
`endif
    output logic                  sram_rd,
    output logic [ADDR_WIDTH-1:0] sram_offset,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int MIN_OFF = delay_to_off(MIN_DELAY_MS, SAMPLERATE);
    localparam int MAX_OFF = delay_to_off(MAX_DELAY_MS, SAMPLERATE);
    localparam int SPACING = voice_spacing(MIN_OFF, MAX_OFF, VOICES);
    localparam int VSHIFT  = $clog2(VOICES);
    localparam int VIDX_W  = (VOICES > 1) ? VSHIFT : 1;
    // Sum of VOICES samples needs log2(VOICES) guard bits.
    localparam int ACC_W   = DATA_WIDTH + VSHIFT;
    localparam int MIX_W   = DATA_WIDTH + 5;
    localparam int CNT_W   = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

    localparam logic [VIDX_W-1:0] LAST_VOICE = VIDX_W'(VOICES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(RATE_DIV - 1);

    if (!voices_legal(VOICES)) begin : g_bad_voices
        $error("chorus_multivoice: VOICES must be 1, 2, 4 or 8");
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    chorus_state_t                state;
    chorus_state_t                state_next;
    logic                         first_q;   // first READ cycle: voice 0 request
    logic [VIDX_W-1:0]            voice_q;   // voice whose read is outstanding
    logic signed [ACC_W-1:0]      acc;
    logic signed [DATA_WIDTH-1:0] dry_q;
    logic [ADDR_WIDTH-1:0]        off_q;     // last offset presented
    logic [CNT_W-1:0]             cnt_q;     // completed samples since LFO step

    logic [ADDR_WIDTH-1:0]        pos [VOICES];
    logic [VIDX_W-1:0]            rd_voice;
    logic                         take_finish;
    logic                         last_voice;
    logic                         lfo_step;
    logic                         freeze_now;

`ifdef CHORUS_LFO_FREEZE_EN
    assign freeze_now = freeze;
`else
    assign freeze_now = 1'b0;
`endif

    assign take_finish = (state == READ) && !first_q && sram_read_finish;
    assign last_voice  = (voice_q == LAST_VOICE);

    // -------------------------------------------------------------------------
    // Per-voice triangle LFOs. Voice v steps by 2*(v+1) so the voices drift
    // apart instead of sweeping in lockstep.
    // -------------------------------------------------------------------------
    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        chorus_lfo #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_lfo (
            .clk       (clk),
            .rst       (rst),
            .step      (lfo_step),
            .step_size (ADDR_WIDTH'(2 * (v + 1))),
            .min_off   (ADDR_WIDTH'(MIN_OFF)),
            .max_off   (ADDR_WIDTH'(MAX_OFF)),
            .init_pos  (ADDR_WIDTH'(MIN_OFF + v * SPACING)),
            .pos       (pos[v])
        );
    end

    // -------------------------------------------------------------------------
    // Sequencer state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        sram_rd     = 1'b0;
        rd_voice    = '0;
        sram_offset = off_q;
        done        = 1'b0;
        lfo_step    = 1'b0;

        case (state)
            IDLE: begin
                if (cs && my_turn) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (first_q) begin
                    sram_rd  = 1'b1;
                    rd_voice = '0;
                end else if (take_finish) begin
                    if (last_voice) begin
                        state_next = MIX;
                    end else begin
                        sram_rd  = 1'b1;
                        rd_voice = voice_q + VIDX_W'(1);
                    end
                end
            end
            MIX: begin
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                lfo_step   = (cnt_q == CNT_LAST) && !freeze_now;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A reset aborts the sample; no request may escape in that cycle.
        if (rst) begin
            sram_rd = 1'b0;
        end
        if (sram_rd) begin
            sram_offset = pos[rd_voice];
        end
    end

    // -------------------------------------------------------------------------
    // Dry/wet blend. Weights sum to 16, so the weighted sum stays within
    // MIX_W signed bits and the shifted result always fits DATA_WIDTH.
    // -------------------------------------------------------------------------
    logic [4:0]              mix_eff;
    logic signed [MIX_W-1:0] dry_ext;
    logic signed [MIX_W-1:0] wet_ext;
    logic signed [MIX_W-1:0] w_wet;
    logic signed [MIX_W-1:0] w_dry;
    logic signed [MIX_W-1:0] mixed;

    assign mix_eff = (mix > 5'd16) ? 5'd16 : mix;
    assign dry_ext = MIX_W'(dry_q);
    // Arithmetic shift averages the voices (rounds toward -infinity).
    assign wet_ext = MIX_W'(acc >>> VSHIFT);
    assign w_wet   = MIX_W'(mix_eff);
    assign w_dry   = MIX_W'(MIX_FULL) - w_wet;
    assign mixed   = dry_ext * w_dry + wet_ext * w_wet;

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            first_q  <= 1'b0;
            voice_q  <= '0;
            acc      <= '0;
            dry_q    <= '0;
            off_q    <= '0;
            cnt_q    <= '0;
            data_out <= '0;
        end else begin
            first_q <= 1'b0;
            if (sram_rd) begin
                off_q <= sram_offset;
            end

            case (state)
                IDLE: begin
                    if (cs && my_turn) begin
                        dry_q   <= data_in;
                        acc     <= '0;
                        voice_q <= '0;
                        first_q <= 1'b1;
                    end
                end
                READ: begin
                    if (take_finish) begin
                        acc <= acc + ACC_W'($signed(sram_data_in));
                        if (!last_voice) begin
                            voice_q <= voice_q + VIDX_W'(1);
                        end
                    end
                end
                MIX: begin
                    data_out <= DATA_WIDTH'(mixed >>> MIX_SHIFT);
                end
                DONE: begin
                    if (!freeze_now) begin
                        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chorus_multivoice.sv
// -----------------------------------------------------------------------------
// tb_chorus_multivoice
//
// Self-checking bench for chorus_multivoice (default parameters). A driver
// issues samples and pushes the expected tap offsets and output sample into
// queues computed from a behavioural model; a smart_ram responder checks each
// read request against the offset queue and answers after a random delay; a
// monitor checks every done pulse against the output queue.
// Build with +define+CHORUS_LFO_FREEZE_EN to also exercise freeze.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_chorus_multivoice;

    localparam int DW       = 16;
    localparam int AW       = 13;
    localparam int VOICES   = 4;
    localparam int RATE_DIV = 10;
    localparam int MIN_OFF  = 2 * 10 * 48000 / 1000;
    localparam int MAX_OFF  = 2 * 25 * 48000 / 1000;
    localparam int TIMEOUT  = 2000;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs = 1'b0;
    logic          my_turn = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [4:0]    mix = '0;
    logic [DW-1:0] sram_data_in = '0;
    logic          sram_read_finish = 1'b0;
    logic          frz_on = 1'b0;
    logic          sram_rd;
    logic [AW-1:0] sram_offset;
    logic          done;
    logic [DW-1:0] data_out;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    chorus_multivoice dut (
        .clk              (clk),
        .rst              (rst),
        .cs               (cs),
        .my_turn          (my_turn),
        .data_in          (data_in),
        .mix              (mix),
        .sram_data_in     (sram_data_in),
        .sram_read_finish (sram_read_finish),
`ifdef CHORUS_LFO_FREEZE_EN
        .freeze           (frz_on),
`endif
        .sram_rd          (sram_rd),
        .sram_offset      (sram_offset),
        .done             (done),
        .data_out         (data_out)
    );

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_off_q[$];
    logic [DW-1:0] rd_data_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    // ---------------- reference model ----------------
    int m_pos[VOICES];
    bit m_down[VOICES];
    int m_cnt;

    function automatic void model_reset();
        int spacing;
        spacing = (MAX_OFF - MIN_OFF) / VOICES;
        spacing = spacing - (spacing % 2);
        for (int v = 0; v < VOICES; v++) begin
            m_pos[v]  = MIN_OFF + v * spacing;
            m_down[v] = 1'b0;
        end
        m_cnt = 0;
    endfunction

    function automatic void model_advance(input logic frz);
        if (frz) return;
        if (m_cnt == RATE_DIV - 1) begin
            m_cnt = 0;
            for (int v = 0; v < VOICES; v++) begin
                int step;
                step = 2 * (v + 1);
                if (!m_down[v]) begin
                    if (m_pos[v] + step >= MAX_OFF) begin m_pos[v] = MAX_OFF; m_down[v] = 1'b1; end
                    else m_pos[v] = m_pos[v] + step;
                end else begin
                    if (m_pos[v] - step <= MIN_OFF) begin m_pos[v] = MIN_OFF; m_down[v] = 1'b0; end
                    else m_pos[v] = m_pos[v] - step;
                end
            end
        end else begin
            m_cnt++;
        end
    endfunction

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic logic [DW-1:0] model_mix(input logic [DW-1:0] din, input logic [4:0] mx,
                                                input int sum);
        int dry, wet, m;
        dry = int'($signed(din));
        wet = floor_div(sum, VOICES);
        m   = (mx > 16) ? 16 : int'(mx);
        return DW'(floor_div(dry * (16 - m) + wet * m, 16));
    endfunction

    // ---------------- smart_ram responder ----------------
    logic flush = 1'b0;
    int   max_delay = 1;
    int   rd_cnt = 0;

    initial begin
        bit pending;
        int wait_left;
        pending   = 1'b0;
        wait_left = 0;
        forever begin
            @(negedge clk);
            if (!flush && sram_rd) begin
                rd_cnt++;
                check("rd_while_pending", pending, 0);
                check("rd_expected", exp_off_q.size() > 0, 1);
                if (exp_off_q.size() > 0) check("sram_offset", sram_offset, exp_off_q.pop_front());
                pending   = 1'b1;
                wait_left = $urandom_range(1, max_delay);
            end
            @(posedge clk);
            #1;
            sram_read_finish = 1'b0;
            if (flush) begin
                pending = 1'b0;
            end else if (pending) begin
                wait_left--;
                if (wait_left == 0) begin
                    pending          = 1'b0;
                    sram_read_finish = 1'b1;
                    sram_data_in     = (rd_data_q.size() > 0) ? rd_data_q.pop_front() : DW'($urandom);
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    int done_cnt = 0;
    int done_cyc = 0;

    initial begin
        bit prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done) check("done_pulse_width", done, 0);
            prev_done = done;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("data_out", data_out, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    int            issued = 0;
    logic [DW-1:0] cur_rv[VOICES];
    logic [DW-1:0] last_exp;

    task automatic fill_rand();
        for (int v = 0; v < VOICES; v++) cur_rv[v] = DW'($urandom);
    endtask

    task automatic fill_const(input logic [DW-1:0] val);
        for (int v = 0; v < VOICES; v++) cur_rv[v] = val;
    endtask

    task automatic apply_reset();
        rst = 1'b1; cs = 1'b0; my_turn = 1'b0; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_sram_rd", sram_rd, 0);
        check("rst_done", done, 0);
        check("rst_data_out", data_out, 0);
        check("rst_sram_offset", sram_offset, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete(); exp_off_q.delete(); rd_data_q.delete();
        done_cnt = 0; issued = 0;
        model_reset();
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic run_sample(input logic [DW-1:0] din, input logic [4:0] mx);
        int sum, acc_cyc, t;
        sum = 0;
        t   = 0;
        for (int v = 0; v < VOICES; v++) begin
            exp_off_q.push_back(AW'(m_pos[v]));
            rd_data_q.push_back(cur_rv[v]);
            sum += int'($signed(cur_rv[v]));
        end
        last_exp = model_mix(din, mx, sum);
        exp_q.push_back(last_exp);
        model_advance(frz_on);
        issued++;
        @(posedge clk);
        #1;
        cs = 1'b1; my_turn = 1'b1; data_in = din; mix = mx; acc_cyc = cyc;
        @(posedge clk);
        #1;
        // Mid-sample input activity must not disturb the running sample.
        data_in = DW'($urandom);
        cs      = 1'($urandom_range(0, 1));
        my_turn = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        cs = 1'b0; my_turn = 1'b0;
        while (done_cnt < issued && t < TIMEOUT) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("done_seen", done_cnt >= issued, 1);
        if (max_delay == 1) check("latency", done_cyc - acc_cyc, VOICES + 3);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rd0, t;
        model_reset();
        apply_reset();

        // Directed blends.
        max_delay = 1;
        fill_rand();                 run_sample(16'h1234, 5'd0);
        cur_rv[0] = 16'h0100; cur_rv[1] = 16'h0200;
        cur_rv[2] = 16'h0300; cur_rv[3] = 16'h0400;
        run_sample(16'h5555, 5'd16);
        fill_const(16'h7FFF);        run_sample(16'h7FFF, 5'd8);
        fill_const(16'h8000);        run_sample(16'h8000, 5'd8);
        fill_rand();                 run_sample(DW'($urandom), 5'd20);

        // Grant presented only during DONE must not start a sample.
        fill_rand();
        run_sample(DW'($urandom), 5'd5);
        cs = 1'b1; my_turn = 1'b1;
        @(posedge clk);
        #1;
        cs = 1'b0; my_turn = 1'b0;
        rd0 = rd_cnt;
        repeat (6) @(negedge clk);
        check("no_accept_in_done", rd_cnt - rd0, 0);
        check("data_out_hold", data_out, last_exp);

        // Random traffic with variable memory latency.
        max_delay = 4;
        for (int i = 0; i < 40; i++) begin
            fill_rand();
            run_sample(DW'($urandom), 5'($urandom_range(0, 31)));
        end

        // Abort in READ after the second request.
        max_delay = 2;
        fill_rand();
        for (int v = 0; v < VOICES; v++) begin
            exp_off_q.push_back(AW'(m_pos[v]));
            rd_data_q.push_back(cur_rv[v]);
        end
        @(posedge clk);
        #1;
        cs = 1'b1; my_turn = 1'b1; data_in = DW'($urandom); mix = 5'd9;
        @(posedge clk);
        #1;
        cs = 1'b0; my_turn = 1'b0;
        rd0 = rd_cnt;
        t   = 0;
        while (rd_cnt < rd0 + 2 && t < TIMEOUT) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("reads_before_abort", rd_cnt - rd0, 2);
        apply_reset();
        repeat (4) @(negedge clk);
        check("no_done_after_abort", done_cnt, 0);

        // Long sweep: voice 3 reaches the top after 45 steps and turns back.
        max_delay = 1;
        for (int i = 0; i < 470; i++) begin
            fill_rand();
            run_sample(DW'($urandom), 5'($urandom_range(0, 16)));
        end

`ifdef CHORUS_LFO_FREEZE_EN
        frz_on = 1'b1;
        for (int i = 0; i < 30; i++) begin
            fill_rand();
            run_sample(DW'($urandom), 5'($urandom_range(0, 31)));
        end
        frz_on = 1'b0;
        fill_rand();
        run_sample(DW'($urandom), 5'd20);
`endif

        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp_off_q_drained", exp_off_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
